// File: rtl/output_scheduler_pkg.sv
// output_scheduler_pkg
//   Shared definitions for the output scheduler slice: FSM state encoding,
//   requester (source) encoding, display special codes and the default
//   divider data width.
//   No ports (package).
package output_scheduler_pkg;

  // Default magnitude width shared with the BCD divider (holds up to 16383).
  localparam int OD_N = 14;

  // Display special codes
  localparam logic [3:0] BLANK_CODE = 4'hA;
  localparam logic [3:0] ERR_CODE   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } os_state_e;

  typedef enum logic {
    SRC_RES = 1'b0,
    SRC_ENT = 1'b1
  } os_src_e;

endpackage

// File: rtl/output_scheduler_rr_arb.sv
// os_rr_arb
//   Two-requester round-robin arbiter. Grants are combinational and only
//   produced while gnt_en is high. On a tie the preferred requester wins;
//   after every grant the preference moves to the other requester, so the
//   requester not granted last wins the next tie. Preference starts at RES.
//   Ports:
//     Clock    in   rising-edge clock
//     Reset    in   asynchronous active-low reset
//     gnt_en   in   allow a grant this cycle
//     req_res  in   result requester
//     req_ent  in   entry requester
//     gnt_res  out  grant to result requester
//     gnt_ent  out  grant to entry requester
module os_rr_arb
  import output_scheduler_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic gnt_en,
  input  logic req_res,
  input  logic req_ent,
  output logic gnt_res,
  output logic gnt_ent
);

  os_src_e pref;

  always_comb begin
    gnt_res = 1'b0;
    gnt_ent = 1'b0;
    if (gnt_en) begin
      if (req_res && req_ent) begin
        gnt_res = (pref == SRC_RES);
        gnt_ent = (pref == SRC_ENT);
      end else begin
        gnt_res = req_res;
        gnt_ent = req_ent;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pref <= SRC_RES;
    end else if (gnt_res) begin
      pref <= SRC_ENT;
    end else if (gnt_ent) begin
      pref <= SRC_RES;
    end
  end

endmodule

// File: rtl/output_scheduler.sv
// output_scheduler
//   Shares the BCD divider between the result path (RES) and the operand
//   entry echo path (ENT). A granted request is latched, loaded into the
//   divider, waited out for DIV_CYCLES, and its four digits plus sign and
//   overflow flag are captured into the display registers while the
//   requester is acknowledged. Magnitudes above MAX_VAL skip the divider
//   and capture the error code on all digits.
//   Optional feature macro: OS_BLANK_EN -- blank leading zero digits
//   (disp3 downward, disp0 never) with code 4'hA on non-error captures.
//   Ports:
//     Clock, Reset             clock / async active-low reset
//     req_res, res_data,       result request (level), magnitude, sign,
//     res_neg, ack_res         one-cycle acknowledge
//     req_ent, ent_data,       entry request (level), magnitude, sign,
//     ent_neg, ack_ent         one-cycle acknowledge
//     od_load, od_data         divider load pulse and operand
//     od_bcd0..od_bcd3         divider digit outputs (bcd0 least significant)
//     disp0..disp3             captured display digits
//     disp_neg, disp_err       captured sign and overflow flag
//     disp_src                 captured source (0 = RES, 1 = ENT)
//     disp_valid               set by the first capture
//     busy                     high outside IDLE
module output_scheduler
  import output_scheduler_pkg::*;
#(
  parameter int DATA_W     = OD_N,
  parameter int DIV_CYCLES = 4,
  parameter int MAX_VAL    = 9999
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req_res,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_neg,
  output logic              ack_res,
  input  logic              req_ent,
  input  logic [DATA_W-1:0] ent_data,
  input  logic              ent_neg,
  output logic              ack_ent,
  output logic              od_load,
  output logic [DATA_W-1:0] od_data,
  input  logic [3:0]        od_bcd0,
  input  logic [3:0]        od_bcd1,
  input  logic [3:0]        od_bcd2,
  input  logic [3:0]        od_bcd3,
  output logic [3:0]        disp0,
  output logic [3:0]        disp1,
  output logic [3:0]        disp2,
  output logic [3:0]        disp3,
  output logic              disp_neg,
  output logic              disp_err,
  output logic              disp_src,
  output logic              disp_valid,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [DATA_W-1:0] MAX_MAG  = DATA_W'(MAX_VAL);

  // Digit formatting applied on a non-error capture.
  function automatic logic [15:0] fmt_digits(input logic [15:0] d);
    logic [15:0] r;
    r = d;
`ifdef OS_BLANK_EN
    // Blank from the top digit down until the first non-zero digit.
    if (r[15:12] == 4'd0) begin
      r[15:12] = BLANK_CODE;
      if (r[11:8] == 4'd0) begin
        r[11:8] = BLANK_CODE;
        if (r[7:4] == 4'd0) begin
          r[7:4] = BLANK_CODE;
        end
      end
    end
`endif
    return r;
  endfunction

  os_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  os_src_e           src_q;
  logic              err_q;
  logic              sign_q;
  logic [DATA_W-1:0] opnd_q;

  logic              gnt_en, gnt_res, gnt_ent, gnt_any;
  logic [DATA_W-1:0] sel_mag;
  logic              sel_neg;
  logic              mag_ovf;

  assign gnt_en  = (state_q == ST_IDLE);
  assign gnt_any = gnt_res | gnt_ent;
  assign sel_mag = gnt_ent ? ent_data : res_data;
  assign sel_neg = gnt_ent ? ent_neg : res_neg;
  assign mag_ovf = (sel_mag > MAX_MAG);

  os_rr_arb u_arb (
    .Clock   (Clock),
    .Reset   (Reset),
    .gnt_en  (gnt_en),
    .req_res (req_res),
    .req_ent (req_ent),
    .gnt_res (gnt_res),
    .gnt_ent (gnt_ent)
  );

  always_comb begin
    state_d = state_q;
    od_load = 1'b0;
    ack_res = 1'b0;
    ack_ent = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Overflowing magnitudes never reach the divider.
        if (gnt_any) state_d = mag_ovf ? ST_CAPTURE : ST_ISSUE;
      end
      ST_ISSUE: begin
        od_load = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        ack_res = (src_q == SRC_RES);
        ack_ent = (src_q == SRC_ENT);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign od_data = od_load ? opnd_q : '0;

  // Grant stage: control state and request attributes
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= SRC_RES;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (gnt_any) begin
        src_q <= gnt_ent ? SRC_ENT : SRC_RES;
        err_q <= mag_ovf;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (gnt_any) begin
      opnd_q <= sel_mag;
      sign_q <= sel_neg;
    end
  end

  // Capture stage: display registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      {disp3, disp2, disp1, disp0} <= '0;
      disp_neg   <= 1'b0;
      disp_err   <= 1'b0;
      disp_src   <= 1'b0;
      disp_valid <= 1'b0;
    end else if (state_q == ST_CAPTURE) begin
      {disp3, disp2, disp1, disp0} <= err_q ? {4{ERR_CODE}}
                                            : fmt_digits({od_bcd3, od_bcd2, od_bcd1, od_bcd0});
      disp_neg   <= sign_q;
      disp_err   <= err_q;
      disp_src   <= src_q;
      disp_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_scheduler.sv
// tb_output_scheduler
//   Scoreboard bench for output_scheduler. Requesters push the expected
//   display response per source when they raise a request; a monitor pops
//   and compares on every acknowledge. The divider is modelled
//   behaviourally with DIV_CYCLES latency and garbage digits while busy.
module tb_output_scheduler;
  import output_scheduler_pkg::*;

  localparam int DW = OD_N;

  typedef struct {
    int          mag;
    bit          neg;
    bit          err;
    logic [15:0] dig;
  } exp_t;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          req_res, res_neg, ack_res;
  logic          req_ent, ent_neg, ack_ent;
  logic [DW-1:0] res_data, ent_data, od_data;
  logic          od_load;
  logic [3:0]    od_bcd0, od_bcd1, od_bcd2, od_bcd3;
  logic [3:0]    disp0, disp1, disp2, disp3;
  logic          disp_neg, disp_err, disp_src, disp_valid, busy;
  logic [15:0]   bcd_bus;

  assign {od_bcd3, od_bcd2, od_bcd1, od_bcd0} = bcd_bus;

  output_scheduler dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .req_res    (req_res),
    .res_data   (res_data),
    .res_neg    (res_neg),
    .ack_res    (ack_res),
    .req_ent    (req_ent),
    .ent_data   (ent_data),
    .ent_neg    (ent_neg),
    .ack_ent    (ack_ent),
    .od_load    (od_load),
    .od_data    (od_data),
    .od_bcd0    (od_bcd0),
    .od_bcd1    (od_bcd1),
    .od_bcd2    (od_bcd2),
    .od_bcd3    (od_bcd3),
    .disp0      (disp0),
    .disp1      (disp1),
    .disp2      (disp2),
    .disp3      (disp3),
    .disp_neg   (disp_neg),
    .disp_err   (disp_err),
    .disp_src   (disp_src),
    .disp_valid (disp_valid),
    .busy       (busy)
  );

  always #5 Clock = ~Clock;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   div_gen = 0;
  exp_t q_res[$];
  exp_t q_ent[$];
  int   src_log[$];
  bit   pref;   // requester expected to win a tie (0 = RES)

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, expv);
    end
  endfunction

  // Expected display contents from the decimal value of the magnitude.
  function automatic exp_t model(int mag, bit neg);
    exp_t e;
    int   d[4];
    e.mag = mag;
    e.neg = neg;
    e.err = (mag > 9999);
    if (e.err) begin
      e.dig = 16'hEEEE;
    end else begin
      d[0] = mag % 10;
      d[1] = (mag / 10) % 10;
      d[2] = (mag / 100) % 10;
      d[3] = (mag / 1000) % 10;
`ifdef OS_BLANK_EN
      if (mag < 1000) d[3] = 10;
      if (mag < 100)  d[2] = 10;
      if (mag < 10)   d[1] = 10;
`endif
      e.dig = {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
    end
    return e;
  endfunction

  function automatic int rnd_mag();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 2)      return int'($urandom_range(10000, 16383));
    else if (r < 4) return int'($urandom_range(0, 9));
    else            return int'($urandom_range(0, 9999));
  endfunction

  // Behavioural divider: digits show 0xF while converting and become
  // valid DIV_CYCLES cycles after the load edge.
  initial begin
    bcd_bus = '0;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        bcd_bus = '0;
        div_gen++;
      end else if (od_load) begin
        automatic int g = div_gen;
        automatic int v = int'(od_data);
        fork
          begin
            @(posedge Clock); #1;
            if (g == div_gen) bcd_bus = 16'hFFFF;
            repeat (4) @(posedge Clock);
            #1;
            if (g == div_gen)
              bcd_bus = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
          end
        join_none
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e, pend;
    bit   pend_src, chk_pend, src;
    int   loads, ld_data, ld_cyc;
    chk_pend = 0; loads = 0; ld_data = 0; ld_cyc = 0; pend_src = 0;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        loads    = 0;
        chk_pend = 0;
      end else begin
        if (chk_pend) begin
          chk("disp_digits", int'({disp3, disp2, disp1, disp0}), int'(pend.dig));
          chk("disp_neg", int'(disp_neg), int'(pend.neg));
          chk("disp_err", int'(disp_err), int'(pend.err));
          chk("disp_src", int'(disp_src), int'(pend_src));
          chk("disp_valid", int'(disp_valid), 1);
          chk_pend = 0;
        end
        if (od_load) begin
          loads++;
          ld_data = int'(od_data);
          ld_cyc  = cyc;
        end
        if (ack_res || ack_ent) begin
          chk("single_ack", int'(ack_res & ack_ent), 0);
          src = ack_ent;
          if ((src ? q_ent.size() : q_res.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: src=%0d acked, want no ack", src);
          end else begin
            e = src ? q_ent.pop_front() : q_res.pop_front();
            chk("loads_per_ack", loads, e.err ? 0 : 1);
            if (!e.err) begin
              chk("od_data", ld_data, e.mag);
              chk("load_to_ack", cyc - ld_cyc, 5);
            end
            pend     = e;
            pend_src = src;
            chk_pend = 1;
          end
          loads = 0;
          src_log.push_back(int'(src));
        end
      end
    end
  end

  // Raise one request at a negedge, hold until ack, then drop.
  task automatic do_req(input bit is_ent, input int mag, input bit neg,
                        input bit timed, input bit scramble);
    exp_t e;
    bit   got;
    int   c0;
    e   = model(mag, neg);
    got = 0;
    if (is_ent) begin
      q_ent.push_back(e);
      ent_data = DW'(mag); ent_neg = neg; req_ent = 1'b1;
    end else begin
      q_res.push_back(e);
      res_data = DW'(mag); res_neg = neg; req_res = 1'b1;
    end
    c0 = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clock);
      if (scramble && i == 0) begin
        if (is_ent) begin ent_data = ~ent_data; ent_neg = ~neg; end
        else begin res_data = ~res_data; res_neg = ~neg; end
      end
      got = is_ent ? ack_ent : ack_res;
    end
    if (is_ent) req_ent = 1'b0; else req_res = 1'b0;
    chk(is_ent ? "ack_ent_seen" : "ack_res_seen", int'(got), 1);
    if (got && timed) chk("req_to_ack", cyc - c0, e.err ? 1 : 6);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, m;
    Reset = 1'b0;
    req_res = 0; req_ent = 0; res_data = '0; ent_data = '0; res_neg = 0; ent_neg = 0;
    pref = 0;
    repeat (3) @(negedge Clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ctrl", int'({ack_res, ack_ent, od_load}), 0);
    chk("rst_od_data", int'(od_data), 0);
    chk("rst_disp", int'({disp3, disp2, disp1, disp0}), 0);
    chk("rst_flags", int'({disp_neg, disp_err, disp_src, disp_valid}), 0);
    Reset = 1'b1;

    // Directed cases
    do_req(0, 1234, 0, 1, 1); pref = 1; @(negedge Clock);
    do_req(1, 10000, 0, 1, 1); pref = 0; @(negedge Clock);
    do_req(0, 7, 1, 1, 0);    pref = 1; @(negedge Clock);
    do_req(1, 0, 1, 1, 0);    pref = 0; @(negedge Clock);
    do_req(0, 9999, 0, 1, 0); pref = 1; @(negedge Clock);
    do_req(1, 16383, 1, 1, 0); pref = 0; @(negedge Clock);

    // Both held: strict alternation starting with the preferred requester
    n0 = src_log.size();
    fork
      for (int k = 0; k < 4; k++) begin do_req(0, 5, 0, 0, 0); @(negedge Clock); end
      for (int k = 0; k < 4; k++) begin do_req(1, 6, 0, 0, 0); @(negedge Clock); end
    join
    @(negedge Clock);
    chk("alt_count", src_log.size() - n0, 8);
    if (src_log.size() - n0 == 8)
      for (int k = 0; k < 8; k++) chk("alt_order", src_log[n0 + k], int'(pref ^ k[0]));

    // Short-lived ENT request while RES is in service
    n0 = src_log.size();
    fork
      do_req(0, 321, 0, 1, 0);
      begin
        repeat (3) @(negedge Clock);
        ent_data = DW'(55); req_ent = 1'b1;
        @(negedge Clock);
        req_ent = 1'b0;
      end
    join
    pref = 1;
    @(negedge Clock);
    chk("drop_served", src_log.size() - n0, 1);
    m = 0;
    foreach (src_log[k]) if (k >= n0 && src_log[k] == 1) m++;
    chk("drop_no_ent_ack", m, 0);

    // Reset during WAIT
    res_data = DW'(4321); res_neg = 1'b1; req_res = 1'b1;
    repeat (3) @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ctrl", int'({ack_res, ack_ent, od_load}), 0);
    chk("midrst_disp", int'({disp3, disp2, disp1, disp0}), 0);
    chk("midrst_flags", int'({disp_neg, disp_err, disp_src, disp_valid}), 0);
    req_res = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    pref = 0;
    do_req(0, 2468, 0, 1, 0); pref = 1; @(negedge Clock);

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      int mode, ma, mb;
      bit na, nb;
      mode = int'($urandom_range(0, 2));
      ma = rnd_mag(); mb = rnd_mag();
      na = 1'($urandom_range(0, 1)); nb = 1'($urandom_range(0, 1));
      n0 = src_log.size();
      if (mode == 0) begin
        do_req(0, ma, na, 1, 1'($urandom_range(0, 1))); pref = 1;
      end else if (mode == 1) begin
        do_req(1, mb, nb, 1, 1'($urandom_range(0, 1))); pref = 0;
      end else begin
        fork
          do_req(0, ma, na, 0, 0);
          do_req(1, mb, nb, 0, 0);
        join
        @(negedge Clock);
        chk("tie_count", src_log.size() - n0, 2);
        if (src_log.size() - n0 == 2) begin
          chk("tie_first", src_log[n0], int'(pref));
          chk("tie_second", src_log[n0 + 1], int'(!pref));
        end
      end
      @(negedge Clock);
    end

    repeat (3) @(negedge Clock);
    chk("res_q_empty", q_res.size(), 0);
    chk("ent_q_empty", q_ent.size(), 0);
    chk("idle_busy", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_scheduler.md
Name: output_scheduler

Overview:
- Shares the single BCD divider datapath between two requesters: the computed result path (RES) and the operand-entry echo path (ENT).
- For each granted request it arbitrates, issues the divider load, waits out the conversion, captures the four BCD digits plus sign and error flags into display registers, and acknowledges the requester.
- Sits between the calculator core / keypad entry logic and the 7-segment display driver.

Parameters:
DATA_W, `OD_N, magnitude width; matches the divider data width.
DIV_CYCLES, 4, cycles from the cycle after the load pulse until all four divider digits are valid.
MAX_VAL, 9999, largest magnitude displayable; anything larger is flagged as an error.

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
req_res  in  1  result request; level, held until ack_res
res_data  in  DATA_W  result magnitude
res_neg  in  1  result sign (1 = negative)
ack_res  out  1  one-cycle acknowledge; display updated for RES
req_ent  in  1  entry request; level, held until ack_ent
ent_data  in  DATA_W  entry magnitude
ent_neg  in  1  entry sign
ack_ent  out  1  one-cycle acknowledge for ENT
od_load  out  1  divider load pulse
od_data  out  DATA_W  divider operand
od_bcd0..od_bcd3  in  4 each  divider digit outputs, bcd0 is least significant
disp0..disp3  out  4 each  captured display digits
disp_neg  out  1  captured sign
disp_err  out  1  captured overflow flag
disp_src  out  1  0 = RES, 1 = ENT
disp_valid  out  1  set by the first capture; cleared only by reset
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, Reset=0): state=IDLE, all outputs 0, rr pointer = RES.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - If any request is pending, grant one. The operand, sign and source are latched on the grant edge; requester data may change after that edge.
  - If magnitude > MAX_VAL, go directly to CAPTURE with the error flag set. Otherwise go to ISSUE.
- Arbitration:
  - A single request wins.
  - If both requests are pending, grant goes to the requester not granted last. rr updates on each grant.
  - A request dropped before its grant is simply not served.
- ISSUE: od_load=1 and od_data=latched operand for exactly this cycle; next state WAIT; wait counter = 0.
- WAIT: counter increments each cycle; after DIV_CYCLES cycles go to CAPTURE. od_load=0.
- CAPTURE (one cycle):
  - disp0..3 <= od_bcd0..3, or 4'hE for all four digits on error.
  - disp_neg <= latched sign; disp_err <= error flag; disp_src <= source; disp_valid <= 1.
  - The matching ack is high during this cycle; next state IDLE.
- Latency:
  - Normal request: grant at edge t, od_load during t+1, capture and ack at t+6 (DIV_CYCLES=4), so 7 cycles from request seen to display update.
  - Error request: ack at t+1.
- Back-to-back requests: a new grant is possible in the IDLE cycle immediately after CAPTURE. A requester must deassert on ack; a request still high in the next IDLE is treated as new.
- od_load is never asserted outside ISSUE. Only one ack is asserted per cycle.
- Reset mid-operation returns to IDLE with no ack issued; the divider shares the same Reset.
- Negative zero: the sign is passed through unchanged (disp_neg=1 with digits 0000 is legal).

Optional Feature:
- Macro: OS_BLANK_EN.
- Defined: in CAPTURE (non-error only), leading zero digits from disp3 downward are replaced by blank code 4'hA. disp0 is never blanked, so 7 shows as A,A,A,7.
- Undefined: digits are captured verbatim, so 7 shows as 0,0,0,7.
- Error captures are unaffected either way.

Decomposition:
- Shared include (OUTPUT_INTERFACE.v): state encodings, blank code 4'hA, error code 4'hE, source encodings, OD_N.
- One natural sub-module, os_rr_arb: two-requester round-robin arbiter with grant-enable and last-grant pointer. Everything else stays in the top.

Test Plan:
- req_res=1, res_data=1234, res_neg=0 -> od_load pulses one cycle after grant with od_data=1234. At grant+6: ack_res=1, disp3..0=1,2,3,4, disp_src=0, disp_valid=1.
- req_ent=1, ent_data=10000 -> od_load never asserts; ack_ent one cycle after grant; disp0..3=E, disp_err=1.
- req_res and req_ent both held with values 5 and 6 -> served RES, ENT, RES, ENT alternately. Each ack is preceded by exactly one od_load.
- res_data=7, res_neg=1 -> disp_neg=1. With OS_BLANK_EN: disp3..0=A,A,A,7. Without it: 0,0,0,7.
- Reset pulsed during WAIT -> busy=0 and all disp outputs 0 immediately, no ack. A subsequent request completes normally.
- req_ent raised for 1 cycle while RES is being served, then dropped -> ENT is never acknowledged and od_load fires once only.
